// File: rtl/cmsdk_mcu_rstseq.sv
// Reset request sequencer: merges system reset sources into one stretched episode,
// releases HRESETn then PRESETn with a stagger, and records the reset cause.
module cmsdk_mcu_rstseq #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic       FCLK,
  input  logic       PORESETn,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUPRESET,
  input  logic       WDOGRESREQ,
  input  logic       DBGRESETREQ,
  input  logic       CAUSECLR,
  output logic       HRESETn,
  output logic       PRESETn,
  output logic       DBGRESETn,
  output logic [3:0] RSTCAUSE,
  output logic       BUSY
);

  typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             por_phase, por_phase_nxt;
  logic             hresetn_nxt, presetn_nxt, dbgresetn_nxt, busy_nxt;
  logic [3:0]       rstcause_nxt;
  logic [2:0]       req_bits;
  logic             req;

  always_ff @(posedge FCLK) begin
    if (!PORESETn) begin
      state     <= ST_HOLD;
      cnt       <= HOLD_LOAD;
      por_phase <= 1'b1;
      HRESETn   <= 1'b0;
      PRESETn   <= 1'b0;
      DBGRESETn <= 1'b0;
      RSTCAUSE  <= 4'b1000;
      BUSY      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      por_phase <= por_phase_nxt;
      HRESETn   <= hresetn_nxt;
      PRESETn   <= presetn_nxt;
      DBGRESETn <= dbgresetn_nxt;
      RSTCAUSE  <= rstcause_nxt;
      BUSY      <= busy_nxt;
    end
  end

  // Any request restarts the hold window, whatever phase the episode is in.
  always_comb begin
    req_bits      = {WDOGRESREQ, LOCKUP & LOCKUPRESET, SYSRESETREQ};
    req           = |req_bits;
    state_nxt     = state;
    cnt_nxt       = cnt;
    por_phase_nxt = por_phase;
    hresetn_nxt   = HRESETn;
    presetn_nxt   = PRESETn;

    case (state)
      ST_HOLD: begin
        if (req) begin
          cnt_nxt = HOLD_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt     = ST_STAGGER;
          hresetn_nxt   = 1'b1;
          cnt_nxt       = STAGGER_LOAD;
          por_phase_nxt = 1'b0;
        end
      end
      ST_STAGGER: begin
        if (req) begin
          state_nxt   = ST_HOLD;
          hresetn_nxt = 1'b0;
          cnt_nxt     = HOLD_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt   = ST_RUN;
          presetn_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (req) begin
          state_nxt   = ST_HOLD;
          hresetn_nxt = 1'b0;
          presetn_nxt = 1'b0;
          cnt_nxt     = HOLD_LOAD;
        end
      end
      default: begin
        state_nxt   = ST_HOLD;
        hresetn_nxt = 1'b0;
        presetn_nxt = 1'b0;
        cnt_nxt     = HOLD_LOAD;
      end
    endcase

    busy_nxt = (state_nxt != ST_RUN);

    // Debug reset follows the power-on hold, then only its own request.
    dbgresetn_nxt = por_phase_nxt ? 1'b0 : ~DBGRESETREQ;

    // New request bits win over a simultaneous clear.
    rstcause_nxt = (CAUSECLR ? 4'b0000 : RSTCAUSE) | {1'b0, req_bits};
  end

endmodule

// File: tb/tb_cmsdk_mcu_rstseq.sv
// Self-checking bench for cmsdk_mcu_rstseq: directed scenarios plus random traffic
// compared against a cycles-since-last-request model.
module tb_cmsdk_mcu_rstseq;

  localparam int HOLD = 16;
  localparam int STAG = 4;

  logic       FCLK;
  logic       PORESETn;
  logic       SYSRESETREQ, LOCKUP, LOCKUPRESET, WDOGRESREQ, DBGRESETREQ, CAUSECLR;
  logic       HRESETn, PRESETn, DBGRESETn, BUSY;
  logic [3:0] RSTCAUSE;

  int vectors = 0;
  int miscompares = 0;

  // Model: edges since the last request or reset decide the whole reset picture.
  int         since = 0;
  bit         por = 1'b1;
  logic [3:0] m_cause = 4'h8;
  logic       m_dbg = 1'b0;

  cmsdk_mcu_rstseq #(.HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .CNT_W(8)) dut (
    .FCLK(FCLK), .PORESETn(PORESETn), .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP),
    .LOCKUPRESET(LOCKUPRESET), .WDOGRESREQ(WDOGRESREQ), .DBGRESETREQ(DBGRESETREQ),
    .CAUSECLR(CAUSECLR), .HRESETn(HRESETn), .PRESETn(PRESETn), .DBGRESETn(DBGRESETn),
    .RSTCAUSE(RSTCAUSE), .BUSY(BUSY)
  );

  initial begin
    FCLK = 1'b0;
    forever #5 FCLK = ~FCLK;
  end

  function automatic logic [7:0] exp_vec();
    return {since >= HOLD, since >= HOLD + STAG, m_dbg, since < HOLD + STAG, m_cause};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {HRESETn, PRESETn, DBGRESETn, BUSY, RSTCAUSE};
  endfunction

  task automatic step();
    logic req;
    @(posedge FCLK);
    req = SYSRESETREQ | (LOCKUP & LOCKUPRESET) | WDOGRESREQ;
    if (!PORESETn) begin
      since = 0;
      por = 1'b1;
      m_cause = 4'h8;
      m_dbg = 1'b0;
    end else begin
      if (req) since = 0;
      else if (since < 10000) since++;
      m_cause = (CAUSECLR ? 4'h0 : m_cause) | {1'b0, WDOGRESREQ, LOCKUP & LOCKUPRESET, SYSRESETREQ};
      if (since >= HOLD) por = 1'b0;
      m_dbg = por ? 1'b0 : ~DBGRESETREQ;
    end
    #1;
  endtask

  task automatic clear_inputs();
    SYSRESETREQ = 0; LOCKUP = 0; LOCKUPRESET = 0;
    WDOGRESREQ = 0; DBGRESETREQ = 0; CAUSECLR = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    PORESETn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (dut_vec() !== 8'b0001_1000) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %b expected %b", dut_vec(), 8'b0001_1000);
    end
  endtask

  task automatic test_poweron();
    PORESETn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL poweron E0+%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
      if (k == 14 || k == 15 || k == 18 || k == 19) begin
        vectors++;
        if ({HRESETn, PRESETn, DBGRESETn} !== {k >= 15, k >= 19, k >= 15}) begin
          miscompares++;
          $display("[TB] FAIL poweron_edges E0+%0d: got H/P/D %b expected %b",
                   k, {HRESETn, PRESETn, DBGRESETn}, {k >= 15, k >= 19, k >= 15});
        end
      end
    end
  endtask

  task automatic test_sysreq();
    int busy_cycles = 0;
    CAUSECLR = 1'b1;
    step();
    CAUSECLR = 1'b0;
    SYSRESETREQ = 1'b1;
    step();
    SYSRESETREQ = 1'b0;
    if (BUSY) busy_cycles++;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (BUSY) busy_cycles++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL sysreq E+%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (RSTCAUSE !== 4'h1 || busy_cycles != 20) begin
      miscompares++;
      $display("[TB] FAIL sysreq_cause_busy: got cause %h busy %0d expected cause 1 busy 20",
               RSTCAUSE, busy_cycles);
    end
  endtask

  task automatic test_lockup_masked();
    LOCKUP = 1'b1;
    LOCKUPRESET = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec() || !HRESETn || RSTCAUSE !== 4'h1) begin
        miscompares++;
        $display("[TB] FAIL lockup_masked %0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lockup();
    LOCKUPRESET = 1'b1;
    for (int k = 0; k < 3; k++) step();
    LOCKUP = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec() || HRESETn !== (k >= 16) || RSTCAUSE[1] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL lockup L+%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
    LOCKUPRESET = 1'b0;
  endtask

  task automatic test_stagger_retrigger();
    SYSRESETREQ = 1'b1;
    step();
    SYSRESETREQ = 1'b0;
    for (int k = 0; k < 18; k++) step();
    WDOGRESREQ = 1'b1;
    step();
    WDOGRESREQ = 1'b0;
    vectors++;
    if ({HRESETn, PRESETn, RSTCAUSE[2]} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL stagger_retrigger: got H/P/C2 %b expected 001",
               {HRESETn, PRESETn, RSTCAUSE[2]});
    end
    for (int k = 1; k <= 22; k++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec() || (PRESETn && !HRESETn)) begin
        miscompares++;
        $display("[TB] FAIL stagger_after R+%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clr_set();
    CAUSECLR = 1'b1;
    WDOGRESREQ = 1'b1;
    step();
    CAUSECLR = 1'b0;
    WDOGRESREQ = 1'b0;
    vectors++;
    if (RSTCAUSE !== 4'h4) begin
      miscompares++;
      $display("[TB] FAIL clr_set_cause: got %h expected 4", RSTCAUSE);
    end
    for (int k = 0; k < 22; k++) step();
  endtask

  task automatic test_dbg();
    DBGRESETREQ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) DBGRESETREQ = 1'b0;
      step();
      vectors++;
      if (dut_vec() !== exp_vec() || DBGRESETn !== (k >= 5) || !HRESETn || !PRESETn) begin
        miscompares++;
        $display("[TB] FAIL dbg %0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_midhold_reset();
    SYSRESETREQ = 1'b1;
    step();
    SYSRESETREQ = 1'b0;
    for (int k = 0; k < 5; k++) step();
    PORESETn = 1'b0;
    step();
    vectors++;
    if (dut_vec() !== 8'b0001_1000) begin
      miscompares++;
      $display("[TB] FAIL midhold_reset: got %b expected %b", dut_vec(), 8'b0001_1000);
    end
    PORESETn = 1'b1;
    for (int k = 0; k < 22; k++) begin
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL midhold_restart E0+%0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      SYSRESETREQ = ($urandom_range(0, 59) == 0);
      LOCKUP      = ($urandom_range(0, 39) == 0);
      LOCKUPRESET = $urandom_range(0, 1) == 1;
      WDOGRESREQ  = ($urandom_range(0, 79) == 0);
      DBGRESETREQ = ($urandom_range(0, 3) == 0);
      CAUSECLR    = ($urandom_range(0, 15) == 0);
      PORESETn    = ($urandom_range(0, 299) != 0);
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random %0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
    clear_inputs();
    PORESETn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    PORESETn = 1'b0;
    #1;
    test_reset();
    test_poweron();
    test_sysreq();
    test_lockup_masked();
    test_lockup();
    test_stagger_retrigger();
    test_clr_set();
    test_dbg();
    test_midhold_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
